sync_fifo: RTL and testbench

Parametrised single-clock FIFO for buffering between producers and consumers in the same clock domain. It generalises our 2-deep CDC buffer to:

- arbitrary power-of-two depth;
- a selectable standard or first-word-fall-through (FWFT) read mode;
- occupancy and almost-full/almost-empty reporting;
- registered overflow/underflow error pulses.

It uses the same write-port/read-port handshake naming as our CDC FIFOs, so a design can swap one for the other when both sides share a clock.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_fwft_stage.sv | 55 +++++
 rtl/sync_fifo.sv | 151 +++++++++++++++
 tb/tb_sync_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared types and helpers for sync_fifo
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_VALID = 1'b1
    } fwft_state_e;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_fwft_stage.sv
// ============================================================================
// fifo_fwft_stage : first-word-fall-through output register and FSM
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module fifo_fwft_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_nonempty_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  pop_i,
    output logic                  load_o,
    output logic                  rrdy_o,
    output logic [DATA_WIDTH-1:0] dout_o
);

    fwft_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pop_ok;

    // Refill whenever the stage is empty or is being drained this cycle.
    always_comb begin
        pop_ok  = pop_i && (state_q == S_VALID);
        load_o  = mem_nonempty_i && ((state_q == S_EMPTY) || pop_ok);
        state_d = state_q;
        data_d  = data_q;
        if (load_o) begin
            state_d = S_VALID;
            data_d  = mem_data_i;
        end else if (pop_ok) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign rrdy_o = (state_q == S_VALID);
    assign dout_o = data_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, standard or FWFT read, with status and errors
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 8,
    parameter fifo_mode_e MODE       = FIFO_STD,
    parameter int         AFULL_LVL  = DEPTH - 1,
    parameter int         AEMPTY_LVL = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wea_i,
    input  logic [DATA_WIDTH-1:0]         dina_i,
    output logic                          wrdy_o,
    input  logic                          reb_i,
    output logic [DATA_WIDTH-1:0]         doutb_o,
    output logic                          rrdy_o,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic                          afull_o,
    output logic                          aempty_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             LW       = level_width(DEPTH);
    localparam logic [LW-1:0]  FULL_CNT = LW'(DEPTH);
    localparam logic [LW-1:0]  AF_CNT   = LW'(AFULL_LVL);
    localparam logic [LW-1:0]  AE_CNT   = LW'(AEMPTY_LVL);

    if (DATA_WIDTH < 1) begin : g_chk_width
        $error("sync_fifo: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_chk_afull
        $error("sync_fifo: AFULL_LVL out of range 1..DEPTH");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_chk_aempty
        $error("sync_fifo: AEMPTY_LVL out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q, count_d;
    logic                  afull_q, aempty_q;
    logic                  overflow_q, underflow_q;

    logic                  wr_ok, rd_ok, rd_adv, rrdy;
    logic [DATA_WIDTH-1:0] rd_data;

    assign wrdy_o  = (count_q != FULL_CNT);
    assign wr_ok   = wea_i && wrdy_o;
    assign rd_ok   = reb_i && rrdy;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Occupancy counts the FWFT stage too, so only handshakes move it.
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= dina_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            afull_q     <= (count_d >= AF_CNT);
            aempty_q    <= (count_d <= AE_CNT);
            overflow_q  <= wea_i && !wrdy_o;
            underflow_q <= reb_i && !rrdy;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        logic mem_nonempty;

        assign mem_nonempty = ((count_q - LW'(rrdy)) != '0);

        fifo_fwft_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .mem_nonempty_i (mem_nonempty),
            .mem_data_i     (rd_data),
            .pop_i          (reb_i),
            .load_o         (rd_adv),
            .rrdy_o         (rrdy),
            .dout_o         (doutb_o)
        );
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dout_q <= '0;
            end else if (rd_ok) begin
                dout_q <= rd_data;
            end
        end

        assign rrdy    = (count_q != '0);
        assign rd_adv  = rd_ok;
        assign doutb_o = dout_q;
    end

    assign rrdy_o      = rrdy;
    assign level_o     = count_q;
    assign afull_o     = afull_q;
    assign aempty_o    = aempty_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// tb_sync_fifo : drives a standard and an FWFT sync_fifo with shared stimulus
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic          clk, rst, wea, reb;
    logic [DW-1:0] din;

    logic          wrdy_s, rrdy_s, afull_s, aempty_s, ovf_s, udf_s;
    logic [DW-1:0] dout_s;
    logic [3:0]    lvl_s;
    logic          wrdy_f, rrdy_f, afull_f, aempty_f, ovf_f, udf_f;
    logic [DW-1:0] dout_f;
    logic [3:0]    lvl_f;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(FIFO_STD)) u_std (
        .clk_i(clk), .rst_i(rst), .wea_i(wea), .dina_i(din), .wrdy_o(wrdy_s),
        .reb_i(reb), .doutb_o(dout_s), .rrdy_o(rrdy_s), .level_o(lvl_s),
        .afull_o(afull_s), .aempty_o(aempty_s), .overflow_o(ovf_s), .underflow_o(udf_s)
    );

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(FIFO_FWFT)) u_fwft (
        .clk_i(clk), .rst_i(rst), .wea_i(wea), .dina_i(din), .wrdy_o(wrdy_f),
        .reb_i(reb), .doutb_o(dout_f), .rrdy_o(rrdy_f), .level_o(lvl_f),
        .afull_o(afull_f), .aempty_o(aempty_f), .overflow_o(ovf_f), .underflow_o(udf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of every word held, plus for FWFT whether the head is presented.
    logic [DW-1:0] qs[$];
    logic [DW-1:0] qf[$];
    logic [DW-1:0] m_ds, m_df;
    bit            m_vf, m_ovs, m_uds, m_ovf, m_udf;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        qs.delete();
        qf.delete();
        m_ds = '0; m_df = '0;
        m_vf = 0; m_ovs = 0; m_uds = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_step();
        bit w_ok, r_ok, ld;
        int occ;
        w_ok  = wea && (qs.size() < DEPTH);
        r_ok  = reb && (qs.size() > 0);
        m_ovs = wea && !w_ok;
        m_uds = reb && !r_ok;
        if (r_ok) m_ds = qs.pop_front();
        if (w_ok) qs.push_back(din);

        w_ok  = wea && (qf.size() < DEPTH);
        r_ok  = reb && m_vf;
        m_ovf = wea && !w_ok;
        m_udf = reb && !r_ok;
        occ   = qf.size() - (m_vf ? 1 : 0);
        ld    = (occ > 0) && (!m_vf || r_ok);
        if (r_ok) void'(qf.pop_front());
        if (ld) begin
            m_vf = 1;
            m_df = qf[0];
        end else if (r_ok) begin
            m_vf = 0;
        end
        if (w_ok) qf.push_back(din);
    endtask

    task automatic check_outputs();
        chk_eq("std.level",  32'(lvl_s),    32'(qs.size()));
        chk_eq("std.wrdy",   32'(wrdy_s),   32'(qs.size() != DEPTH));
        chk_eq("std.rrdy",   32'(rrdy_s),   32'(qs.size() != 0));
        chk_eq("std.afull",  32'(afull_s),  32'(qs.size() >= AF));
        chk_eq("std.aempty", 32'(aempty_s), 32'(qs.size() <= AE));
        chk_eq("std.ovf",    32'(ovf_s),    32'(m_ovs));
        chk_eq("std.udf",    32'(udf_s),    32'(m_uds));
        chk_eq("std.dout",   32'(dout_s),   32'(m_ds));
        chk_eq("fwft.level", 32'(lvl_f),    32'(qf.size()));
        chk_eq("fwft.wrdy",  32'(wrdy_f),   32'(qf.size() != DEPTH));
        chk_eq("fwft.rrdy",  32'(rrdy_f),   32'(m_vf));
        chk_eq("fwft.afull", 32'(afull_f),  32'(qf.size() >= AF));
        chk_eq("fwft.aempty",32'(aempty_f), 32'(qf.size() <= AE));
        chk_eq("fwft.ovf",   32'(ovf_f),    32'(m_ovf));
        chk_eq("fwft.udf",   32'(udf_f),    32'(m_udf));
        chk_eq("fwft.dout",  32'(dout_f),   32'(m_df));
    endtask

    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
        wea = w; reb = r; din = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Called 1 time unit after an edge; reset is pulsed and released well before the next edge.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wea = 1'b0; reb = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_outputs();

        // Fill, overflow, drain, underflow.
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DW'(i));
        drive(1'b1, 1'b0, 8'h09);
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);

        // Steady state at level 4 with simultaneous traffic.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, DW'(8'h10 + i));
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, DW'(8'h20 + i));
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'h00);

        // Simultaneous write+read at empty, then at full.
        drive(1'b1, 1'b1, 8'h40);
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, DW'(8'h41 + i));
        drive(1'b1, 1'b1, 8'h50);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'h00);

        // FWFT single write falls through two edges later.
        drive(1'b1, 1'b0, 8'hA5);
        chk_eq("fwft.a5_rrdy_n", 32'(rrdy_f), 32'(0));
        drive(1'b0, 1'b0, 8'h00);
        chk_eq("fwft.a5_rrdy_n1", 32'(rrdy_f), 32'(1));
        chk_eq("fwft.a5_dout", 32'(dout_f), 32'(8'hA5));
        drive(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h60 + i));
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 8'h00);

        // Reset mid-burst at level 5, then a clean write/read.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h70 + i));
        mid_reset();
        drive(1'b1, 1'b0, 8'h3C);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        chk_eq("std.3c", 32'(dout_s), 32'(8'h3C));
        chk_eq("fwft.3c", 32'(dout_f), 32'(8'h3C));

        // Random traffic alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 400; i++) begin
            int pw;
            pw = ((i / 50) % 2 == 0) ? 70 : 30;
            drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < (100 - pw)),
                  DW'($urandom));
            if (i == 237) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
